// File: rtl/bram_to_vga_if.sv
// Frame-buffer read port plus VGA pin bundle of the display reader.
// master = display reader side, slave = BRAM / monitor side.
interface bram_to_vga_if;
  logic [16:0] bram_addr;
  logic [11:0] bram_data;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;

  modport master (
    output bram_addr,
    input  bram_data,
    output vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    input  bram_addr,
    output bram_data,
    input  vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/bram_to_vga.sv
// 640x480 VGA timing generator reading a 320x240 RGB444 frame buffer, 2x doubled.
// Pins lag the counters by RD_LAT+1 clocks; no backpressure, the display never stalls.
module bram_to_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic          p_clock,
  input  logic          rst,
  bram_to_vga_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L       = RD_LAT + 1;

  logic [9:0]   h_q, h_d, v_q, v_d;
  logic         active, hs_raw, vs_raw, fs_raw;
  logic [L-1:0] de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [11:0]  rgb_q, rgb_d;
  logic [16:0]  ys, xs;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    active = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    hs_raw = !((h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
    fs_raw = (h_q == '0) && (v_q == '0);
  end

  // y_src*320 built as (y<<8)+(y<<6) so no multiplier is needed
  assign ys            = 17'(v_q >> 1);
  assign xs            = 17'(h_q >> 1);
  assign bus.bram_addr = active ? ((ys << 8) + (ys << 6) + xs) : '0;

  // Bit 0 is the newest stage; bit L-2 lines up with bram_data for the same pixel
  always_comb begin
    de_d  = {de_q[L-2:0], active};
    hs_d  = {hs_q[L-2:0], hs_raw};
    vs_d  = {vs_q[L-2:0], vs_raw};
    fs_d  = {fs_q[L-2:0], fs_raw};
    rgb_d = de_q[L-2] ? bus.bram_data : '0;
  end

  always_ff @(posedge p_clock) begin
    if (!rst) begin
      h_q   <= '0;
      v_q   <= '0;
      de_q  <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
      fs_q  <= '0;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
      rgb_q <= rgb_d;
    end
  end

  assign bus.vga_de      = de_q[L-1];
  assign bus.vga_hsync   = hs_q[L-1];
  assign bus.vga_vsync   = vs_q[L-1];
  assign bus.frame_start = fs_q[L-1];
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
endmodule

// File: tb/tb_bram_to_vga.sv
// Bench: full-size RD_LAT=1 reader plus a shrunk-timing RD_LAT=2 reader with a mid-frame reset,
// both compared every cycle against a pixel-position model of what the screen must show.
module tb_bram_to_vga;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   na, nb;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] mem [2][76800];
  logic [11:0] ra1, rb1, rb2;

  bram_to_vga_if ifa();
  bram_to_vga_if ifb();

  bram_to_vga #(.RD_LAT(1)) dut_a (
    .p_clock(clk), .rst(rst_a), .bus(ifa)
  );

  bram_to_vga #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .RD_LAT(2)
  ) dut_b (
    .p_clock(clk), .rst(rst_b), .bus(ifb)
  );

  always #20 clk = ~clk;

  // BRAM read ports with 1 and 2 clocks of latency
  always @(posedge clk) begin
    ra1 <= mem[0][ifa.bram_addr];
    rb1 <= mem[1][ifb.bram_addr];
    rb2 <= rb1;
  end
  assign ifa.bram_data = ra1;
  assign ifb.bram_data = rb2;

  // Clocks elapsed since the counters were last forced to (0,0)
  always @(posedge clk) begin
    na <= rst_a ? na + 1 : 0;
    nb <= rst_b ? nb + 1 : 0;
  end

  // Pin vector: {addr[16:0], hsync, vsync, de, frame_start, rgb[11:0]}
  function automatic logic [32:0] model(input int id, input int n, input int l,
                                        input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp);
    int ht, vt, h, v, m;
    logic [16:0] addr;
    logic hs, vs, de, fs;
    logic [11:0] rgb;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h = n % ht;
    v = (n / ht) % vt;
    addr = (h < ha && v < va) ? 17'((v / 2) * 320 + h / 2) : 17'd0;
    if (n < l) return {addr, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
    m = n - l;
    h = m % ht;
    v = (m / ht) % vt;
    de  = (h < ha) && (v < va);
    hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
    vs  = !(v >= va + vfp && v < va + vfp + vsw);
    fs  = (h == 0) && (v == 0);
    rgb = de ? mem[id][(v / 2) * 320 + h / 2] : 12'h000;
    return {addr, hs, vs, de, fs, rgb};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  logic [32:0] pa, pb;
  assign pa = {ifa.bram_addr, ifa.vga_hsync, ifa.vga_vsync, ifa.vga_de, ifa.frame_start,
               ifa.vga_r, ifa.vga_g, ifa.vga_b};
  assign pb = {ifb.bram_addr, ifb.vga_hsync, ifb.vga_vsync, ifb.vga_de, ifb.frame_start,
               ifb.vga_r, ifb.vga_g, ifb.vga_b};

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins_a", pa, model(0, na, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      check("pins_b", pb, model(1, nb, 3, 20, 3, 4, 5, 12, 2, 3, 3));
      case (na)
        1:    check("a_fs_early", 33'(pa[12]), 33'(0));
        2: begin
          check("a_fs_first", 33'(pa[12]), 33'(1));
          check("a_de_first", 33'(pa[13]), 33'(1));
          check("a_px0_red",  33'(pa[11:0]), 33'(12'hF00));
        end
        3:    check("a_px1_red",   33'(pa[11:0]), 33'(12'hF00));
        4:    check("a_px2_green", 33'(pa[11:0]), 33'(12'h0F0));
        5:    check("a_px3_green", 33'(pa[11:0]), 33'(12'h0F0));
        640:  check("a_addr_hblank", 33'(pa[32:16]), 33'(0));
        641:  check("a_de_last", 33'(pa[13]), 33'(1));
        642:  check("a_de_off", 33'(pa[13]), 33'(0));
        657:  check("a_hs_before", 33'(pa[15]), 33'(1));
        658:  check("a_hs_fall", 33'(pa[15]), 33'(0));
        753:  check("a_hs_low_end", 33'(pa[15]), 33'(0));
        754:  check("a_hs_rise", 33'(pa[15]), 33'(1));
        802:  check("a_line1_red", 33'(pa[11:0]), 33'(12'hF00));
        1458: check("a_hs_fall2", 33'(pa[15]), 33'(0));
        1602: check("a_line2_blue", 33'(pa[11:0]), 33'(12'h00F));
        2402: check("a_line3_blue", 33'(pa[11:0]), 33'(12'h00F));
        6239: check("a_addr_h639_v7", 33'(pa[32:16]), 33'(1279));
        default: ;
      endcase
      case (nb)
        2:   check("b_fs_early", 33'(pb[12]), 33'(0));
        3: begin
          check("b_fs_first", 33'(pb[12]), 33'(1));
          check("b_de_first", 33'(pb[13]), 33'(1));
        end
        22:  check("b_de_last", 33'(pb[13]), 33'(1));
        23:  check("b_de_off", 33'(pb[13]), 33'(0));
        450: check("b_vs_before", 33'(pb[14]), 33'(1));
        451: check("b_vs_fall", 33'(pb[14]), 33'(0));
        546: check("b_vs_low_end", 33'(pb[14]), 33'(0));
        547: check("b_vs_rise", 33'(pb[14]), 33'(1));
        642: check("b_fs_gap", 33'(pb[12]), 33'(0));
        643: check("b_fs_second", 33'(pb[12]), 33'(1));
        default: ;
      endcase
    end
  end

  initial begin
    int  rst_cnt;
    bit  did_reset;
    rst_cnt   = 0;
    did_reset = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 76800; i++) begin
      mem[0][i] = 12'($urandom_range(1, 4095));
      mem[1][i] = 12'($urandom_range(1, 4095));
    end
    mem[0][0]   = 12'hF00;
    mem[0][1]   = 12'h0F0;
    mem[0][320] = 12'h00F;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int c = 0; c < 6450; c++) begin
      @(negedge clk);
      // second frame of dut_b, counters at v=8 h=7
      if (nb == 903 && !did_reset) begin
        rst_b     = 1'b0;
        did_reset = 1'b1;
        rst_cnt   = 3;
      end else if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_b = 1'b1;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
